i2c_master_rd_slave_reg: RTL and testbench

I2C_MASTER_RD_SLAVE_REG -- requirements
Module: i2c_master_rd_slave_reg

---
 rtl/i2c_pkg.sv | 38 +++
 rtl/i2c_master_rd_slave_reg.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_master_rd_slave_reg.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the register-read I2C master: state encoding,
// bit-slot timing points and a small state classification helper.
package i2c_pkg;

    // One bit-slot is 20 system clocks; SCL is low for counts 0-9, high for 10-19.
    localparam logic [4:0] SLOT_LEN  = 5'd20;
    localparam logic [4:0] SCL_RISE  = 5'd10;
    localparam logic [4:0] DRIVE_PT  = 5'd5;
    localparam logic [4:0] SAMPLE_PT = 5'd15;

    // The SDA register is loaded on the edge that ends the preceding count,
    // so a change "at count N" is scheduled while the counter reads N-1.
    localparam logic [4:0] SLOT_LAST  = SLOT_LEN - 5'd1;
    localparam logic [4:0] RISE_PRE   = SCL_RISE - 5'd1;
    localparam logic [4:0] DRIVE_PRE  = DRIVE_PT - 5'd1;
    localparam logic [4:0] SAMPLE_PRE = SAMPLE_PT - 5'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR_W,
        ST_ACK1,
        ST_REG,
        ST_ACK2,
        ST_RSTART,
        ST_ADDR_R,
        ST_ACK3,
        ST_READ,
        ST_MNACK,
        ST_STOP
    } state_e;

    // Slots in which the slave owns SDA (ACK bits and read data).
    function automatic logic slave_owns_sda(input state_e s);
        return (s == ST_ACK1) || (s == ST_ACK2) || (s == ST_ACK3) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/i2c_master_rd_slave_reg.sv
// Free-running I2C master that repeatedly reads one register byte from a
// fixed slave: START, address+W, register pointer, repeated START,
// address+R, one data byte, master NACK, STOP, then an idle gap.
module i2c_master_rd_slave_reg
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h48,
    parameter logic [7:0] REG_ADDR   = 8'h00,
    parameter int         IDLE_SLOTS = 10
) (
    input  logic       clk_200khz,
    input  logic       rst,
    inout  wire        sda,
    output logic       scl,
    output logic       sda_dir,
    output logic [7:0] data_out
);

    localparam logic [15:0] IDLE_LAST = 16'(IDLE_SLOTS - 1);
    localparam logic [7:0]  ADDR_WR   = {SLAVE_ADDR, 1'b0};
    localparam logic [7:0]  ADDR_RD   = {SLAVE_ADDR, 1'b1};

    state_e      state_q, state_d;
    logic [4:0]  slot_q, slot_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] idle_q, idle_d;
    logic [7:0]  shift_q, shift_d;
    logic        nack_q, nack_d;
    logic        sda_low_q, sda_low_d;
    logic [7:0]  data_q, data_d;

    logic sda_in;
    logic sda_out_low;
    logic slot_end;

    assign sda_in      = sda;
    assign sda_out_low = sda_low_q;
    assign slot_end    = (slot_q == SLOT_LAST);

    // Open-drain SDA: only ever pulled low or released.
    assign sda = sda_out_low ? 1'b0 : 1'bz;

    // SCL is held high through idle and the START slot, otherwise low for
    // the first half of every slot and high for the second half.
    always_comb begin
        scl = 1'b1;
        if (state_q != ST_IDLE && state_q != ST_START) begin
            scl = (slot_q >= SCL_RISE);
        end
    end

    // Direction flag follows slot ownership; reset lands in IDLE, so it is 1.
    always_comb begin
        sda_dir = !slave_owns_sda(state_q);
    end

    assign data_out = data_q;

    // State register plus slot/bit counters, shift register and SDA driver.
    always_ff @(posedge clk_200khz or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            bit_q     <= '0;
            idle_q    <= '0;
            shift_q   <= '0;
            nack_q    <= 1'b0;
            sda_low_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            bit_q     <= bit_d;
            idle_q    <= idle_d;
            shift_q   <= shift_d;
            nack_q    <= nack_d;
            sda_low_q <= sda_low_d;
            data_q    <= data_d;
        end
    end

    // Next-state logic: slot sequencing, SDA edges and bit shifting.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_end ? 5'd0 : slot_q + 5'd1;
        bit_d     = bit_q;
        idle_d    = idle_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        sda_low_d = sda_low_q;
        data_d    = data_q;

        case (state_q)
            ST_IDLE: begin
                sda_low_d = 1'b0;
                if (slot_end) begin
                    if (idle_q == IDLE_LAST) begin
                        idle_d  = '0;
                        state_d = ST_START;
                    end else begin
                        idle_d = idle_q + 16'd1;
                    end
                end
            end

            ST_START: begin
                // SDA falls halfway through the slot while SCL stays high.
                if (slot_q == RISE_PRE) begin
                    sda_low_d = 1'b1;
                end
                if (slot_end) begin
                    state_d = ST_ADDR_W;
                    shift_d = ADDR_WR;
                    bit_d   = '0;
                end
            end

            ST_ADDR_W, ST_REG, ST_ADDR_R: begin
                // MSB of the shift register is the bit on the wire this slot.
                if (slot_q == DRIVE_PRE) begin
                    sda_low_d = !shift_q[7];
                end
                if (slot_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        case (state_q)
                            ST_ADDR_W: state_d = ST_ACK1;
                            ST_REG:    state_d = ST_ACK2;
                            default:   state_d = ST_ACK3;
                        endcase
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            ST_ACK1, ST_ACK2, ST_ACK3: begin
                if (slot_q == DRIVE_PRE) begin
                    sda_low_d = 1'b0;
                end
                if (slot_q == SAMPLE_PT) begin
                    nack_d = sda_in;
                end
                if (slot_end) begin
                    if (nack_q) begin
                        state_d = ST_STOP;
                    end else begin
                        case (state_q)
                            ST_ACK1: begin
                                state_d = ST_REG;
                                shift_d = REG_ADDR;
                            end
                            ST_ACK2: state_d = ST_RSTART;
                            default: begin
                                state_d = ST_READ;
                                shift_d = '0;
                            end
                        endcase
                    end
                end
            end

            ST_RSTART: begin
                // Release with SCL low, then pull low again with SCL high.
                if (slot_q == DRIVE_PRE) begin
                    sda_low_d = 1'b0;
                end
                if (slot_q == SAMPLE_PRE) begin
                    sda_low_d = 1'b1;
                end
                if (slot_end) begin
                    state_d = ST_ADDR_R;
                    shift_d = ADDR_RD;
                    bit_d   = '0;
                end
            end

            ST_READ: begin
                sda_low_d = 1'b0;
                if (slot_q == SAMPLE_PT) begin
                    shift_d = {shift_q[6:0], sda_in};
                end
                if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        // Last bit was captured at mid-high; publish the byte.
                        bit_d   = '0;
                        data_d  = shift_q;
                        state_d = ST_MNACK;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            ST_MNACK: begin
                sda_low_d = 1'b0;
                if (slot_end) begin
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                // Low during SCL low, released while SCL is high.
                if (slot_q == DRIVE_PRE) begin
                    sda_low_d = 1'b1;
                end
                if (slot_q == SAMPLE_PRE) begin
                    sda_low_d = 1'b0;
                end
                if (slot_end) begin
                    state_d = ST_IDLE;
                    idle_d  = '0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                sda_low_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_rd_slave_reg.sv
// Bench for the register-read I2C master: a behavioural slave on the bus
// plus a table of transactions with hand-computed expectations.
module tb_i2c_master_rd_slave_reg;

    logic       clk_200khz = 1'b0;
    logic       rst = 1'b0;
    wire        sda;
    logic       scl;
    logic       sda_dir;
    logic [7:0] data_out;

    logic slv_low = 1'b0;

    pullup (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master_rd_slave_reg dut (
        .clk_200khz (clk_200khz),
        .rst        (rst),
        .sda        (sda),
        .scl        (scl),
        .sda_dir    (sda_dir),
        .data_out   (data_out)
    );

    always #5 clk_200khz = ~clk_200khz;

    localparam logic [7:0] EXP_ADDR_W = 8'h90;
    localparam logic [7:0] EXP_REG    = 8'h00;
    localparam logic [7:0] EXP_ADDR_R = 8'h91;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave / bus monitor ----------------
    logic       cfg_ack1 = 1'b0, cfg_ack2 = 1'b0, cfg_ack3 = 1'b0;
    logic [7:0] cfg_data = 8'h00;

    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       s_busy = 1'b0, s_frame = 1'b0, s_rs_seen = 1'b0;
    int         s_rise = 0;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] cap_aw = 8'hEE, cap_reg = 8'hEE, cap_ar = 8'hEE;
    logic       cap_mnack = 1'b0;
    int         start_cnt = 0, stop_cnt = 0;
    time        t_start = 0, t_stop = 0, t_rise_a = 0, t_rise_b = 0;

    always @(scl or sda or rst) begin
        if (!rst) begin
            s_busy  = 1'b0;
            s_frame = 1'b0;
            s_rise  = 0;
            slv_low = 1'b0;
        end else if (scl && prev_scl && prev_sda && !sda) begin
            if (s_busy) begin
                s_frame   = 1'b1;
                s_rs_seen = 1'b1;
            end else begin
                s_busy    = 1'b1;
                s_frame   = 1'b0;
                s_rs_seen = 1'b0;
                start_cnt++;
                t_start   = $time;
                cap_aw    = 8'hEE;
                cap_reg   = 8'hEE;
                cap_ar    = 8'hEE;
                cap_mnack = 1'b0;
            end
            s_rise = 0;
        end else if (scl && prev_scl && !prev_sda && sda) begin
            s_busy  = 1'b0;
            slv_low = 1'b0;
            stop_cnt++;
            t_stop  = $time;
        end else if (scl && !prev_scl) begin
            s_rise++;
            s_sh = {s_sh[6:0], sda};
            if (!s_frame && s_rise == 2) t_rise_a = $time;
            if (!s_frame && s_rise == 3) t_rise_b = $time;
            if (!s_frame && s_rise == 8)  cap_aw = s_sh;
            if (!s_frame && s_rise == 17) cap_reg = s_sh;
            if (s_frame && s_rise == 8)   cap_ar = s_sh;
            if (s_frame && s_rise == 18)  cap_mnack = sda;
        end else if (!scl && prev_scl) begin
            slv_low = 1'b0;
            if (s_busy) begin
                if (!s_frame) begin
                    if ((s_rise == 8 && cfg_ack1) || (s_rise == 17 && cfg_ack2)) slv_low = 1'b1;
                end else begin
                    if (s_rise == 8 && cfg_ack3) slv_low = 1'b1;
                    else if (cfg_ack3 && s_rise >= 9 && s_rise <= 16) slv_low = !cfg_data[16 - s_rise];
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // ---------------- transaction table ----------------
    typedef struct {
        logic       ack1;
        logic       ack2;
        logic       ack3;
        logic [7:0] sdata;
        int         exp_len;   // clocks from START SDA fall to STOP SDA rise
        logic       exp_rs;
        logic       exp_full;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    task automatic wait_start_after(input int base, input string name);
        int n = 0;
        while (start_cnt == base && n < 2000) begin
            @(posedge clk_200khz); #1;
            n++;
        end
        check(name, start_cnt - base, 1);
    endtask

    task automatic measure_start_delay(input string name);
        int  n = 0;
        logic found = 1'b0;
        while (!found && n < 1000) begin
            @(posedge clk_200khz); #1;
            n++;
            if (sda == 1'b0 && scl == 1'b1) found = 1'b1;
        end
        check(name, n, 210);
    endtask

    initial begin
        int         s_base;
        int         p_base;
        int         n;
        logic [7:0] prev_dout;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 205, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'hA5, 765, 1'b1, 1'b1, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h3C, 765, 1'b1, 1'b1, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h77, 585, 1'b1, 1'b0, 8'h3C};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 385, 1'b0, 1'b0, 8'h3C};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 8'hC3, 765, 1'b1, 1'b1, 8'hC3};

        cfg_ack1 = vecs[0].ack1;
        cfg_ack2 = vecs[0].ack2;
        cfg_ack3 = vecs[0].ack3;
        cfg_data = vecs[0].sdata;

        // Reset held low for 10 clocks.
        rst = 1'b0;
        repeat (10) @(posedge clk_200khz);
        #1;
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_sda_dir", sda_dir, 1);
        check("rst_data_out", data_out, 8'h00);

        s_base = start_cnt;
        p_base = stop_cnt;
        @(negedge clk_200khz);
        rst = 1'b1;
        // 10 idle slots, then SDA falls at count 10 of the START slot.
        measure_start_delay("first_start_delay");
        prev_dout = 8'h00;

        for (int i = 0; i < 6; i++) begin
            wait_start_after(s_base, "start_seen");

            if (vecs[i].exp_full) begin
                // MNACK begins 730 clocks after the START SDA fall.
                repeat (729) @(posedge clk_200khz);
                #1;
                check("dout_before_mnack", data_out, prev_dout);
                check("read_sda_dir", sda_dir, 0);
                @(posedge clk_200khz); #1;
                check("dout_at_mnack", data_out, vecs[i].exp_dout);
                check("mnack_sda_dir", sda_dir, 1);
            end

            n = 0;
            while (stop_cnt == p_base && n < 2000) begin
                @(posedge clk_200khz); #1;
                n++;
            end
            check("stop_seen", stop_cnt - p_base, 1);
            check("txn_len", int'((t_stop - t_start) / 10), vecs[i].exp_len);
            check("addr_w_bits", cap_aw, EXP_ADDR_W);
            if (vecs[i].ack1) check("reg_bits", cap_reg, EXP_REG);
            check("rstart_seen", s_rs_seen, vecs[i].exp_rs);
            if (vecs[i].exp_rs) check("addr_r_bits", cap_ar, EXP_ADDR_R);
            if (vecs[i].exp_full) check("mnack_released", cap_mnack, 1);
            check("data_out_final", data_out, vecs[i].exp_dout);

            $display("txn %0d: ack=%b%b%b slave_data=%h len=%0d aw=%h reg=%h ar=%h data_out=%h",
                     i, vecs[i].ack1, vecs[i].ack2, vecs[i].ack3, vecs[i].sdata,
                     int'((t_stop - t_start) / 10), cap_aw, cap_reg, cap_ar, data_out);

            prev_dout = vecs[i].exp_dout;
            s_base = start_cnt;
            p_base = stop_cnt;
            if (i < 5) begin
                cfg_ack1 = vecs[i + 1].ack1;
                cfg_ack2 = vecs[i + 1].ack2;
                cfg_ack3 = vecs[i + 1].ack3;
                cfg_data = vecs[i + 1].sdata;
            end
        end

        check("scl_period", int'((t_rise_b - t_rise_a) / 10), 20);

        // Reset in the middle of READ bit 4 (slot 33, count 5).
        cfg_ack1 = 1'b1;
        cfg_ack2 = 1'b1;
        cfg_ack3 = 1'b1;
        cfg_data = 8'h5A;
        wait_start_after(s_base, "start_seen_rst");
        repeat (655) @(posedge clk_200khz);
        #1;
        check("pre_rst_scl_low", scl, 0);
        check("pre_rst_sda_dir", sda_dir, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_scl", scl, 1);
        check("mid_rst_sda", sda, 1);
        check("mid_rst_sda_dir", sda_dir, 1);
        check("mid_rst_data_out", data_out, 8'h00);
        $display("txn reset: asserted during READ bit 4, scl=%b sda=%b sda_dir=%b data_out=%h",
                 scl, sda, sda_dir, data_out);
        repeat (3) @(posedge clk_200khz);
        @(negedge clk_200khz);
        rst = 1'b1;
        measure_start_delay("restart_delay");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
